// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// One operation in flight: IDLE accepts, EXEC captures the ALU result, RESP holds it for the owner.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1,
  parameter int CW    = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [31:0]   req0_rs1,
  input  logic [31:0]   req0_rs2,
  input  logic [31:0]   req0_pc,
  input  logic [31:0]   req0_imm,
  input  logic [CW-1:0] req0_ctrl,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [31:0]   req1_rs1,
  input  logic [31:0]   req1_rs2,
  input  logic [31:0]   req1_pc,
  input  logic [31:0]   req1_imm,
  input  logic [CW-1:0] req1_ctrl,
  output logic [31:0]   alu_rs1,
  output logic [31:0]   alu_rs2,
  output logic [31:0]   alu_pc,
  output logic [31:0]   alu_imm,
  output logic [CW-1:0] alu_ctrl,
  input  logic [31:0]   alu_z,
  input  logic [31:0]   alu_bta,
  output logic          resp0_valid,
  input  logic          resp0_ready,
  output logic          resp1_valid,
  input  logic          resp1_ready,
  output logic [31:0]   resp_z,
  output logic [31:0]   resp_bta,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q;
  logic [31:0]   rs1_q, rs2_q, pc_q, imm_q, z_q, bta_q;
  logic [CW-1:0] ctrl_q;
  logic [31:0]   rs1_d, rs2_d, pc_d, imm_d;
  logic [CW-1:0] ctrl_d;
  logic          gnt0, gnt1, accept, owner_done;

  // Grant already implies the matching valid, so ready needs no extra valid term.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (RR_EN) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_q;
        gnt1 = !last_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid && !req0_valid;
    end
  end

  assign accept     = req0_ready || req1_ready;
  assign owner_done = owner_q ? resp1_ready : resp0_ready;

  assign rs1_d  = req1_ready ? req1_rs1  : req0_rs1;
  assign rs2_d  = req1_ready ? req1_rs2  : req0_rs2;
  assign pc_d   = req1_ready ? req1_pc   : req0_pc;
  assign imm_d  = req1_ready ? req1_imm  : req0_imm;
  assign ctrl_d = req1_ready ? req1_ctrl : req0_ctrl;
  assign last_d = accept ? req1_ready : last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is masked by reset so nothing is offered while rst_n is low.
  always_comb begin
    req0_ready  = rst_n && (state_q == IDLE) && gnt0;
    req1_ready  = rst_n && (state_q == IDLE) && gnt1;
    resp0_valid = (state_q == RESP) && !owner_q;
    resp1_valid = (state_q == RESP) && owner_q;
    busy        = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      pc_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
      z_q     <= '0;
      bta_q   <= '0;
    end else begin
      last_q <= last_d;
      if (accept) begin
        owner_q <= req1_ready;
        rs1_q   <= rs1_d;
        rs2_q   <= rs2_d;
        pc_q    <= pc_d;
        imm_q   <= imm_d;
        ctrl_q  <= ctrl_d;
      end
      if (state_q == EXEC) begin
        z_q   <= alu_z;
        bta_q <= alu_bta;
      end
    end
  end

  assign alu_rs1  = rs1_q;
  assign alu_rs2  = rs2_q;
  assign alu_pc   = pc_q;
  assign alu_imm  = imm_q;
  assign alu_ctrl = ctrl_q;
  assign resp_z   = z_q;
  assign resp_bta = bta_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed bench for alu_arbiter
// Instance 0 is round-robin, instance 1 fixed priority; both share the same stimulus.
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  q_valid;
  logic [1:0]  p_ready;
  logic [31:0] q_rs1 [2];
  logic [31:0] q_rs2 [2];
  logic [31:0] q_pc  [2];
  logic [31:0] q_imm [2];
  logic [8:0]  q_ctrl[2];

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic        bsy  [2];
  logic [31:0] a_rs1[2];
  logic [31:0] a_rs2[2];
  logic [31:0] a_pc [2];
  logic [31:0] a_imm[2];
  logic [8:0]  a_ctrl[2];
  logic [31:0] a_z  [2];
  logic [31:0] a_bta[2];
  logic [31:0] rz   [2];
  logic [31:0] rbta [2];

  int n_checks = 0;
  int n_errors = 0;

  // ctrl = {ALUOP[2:0], Asrc, Bsrc, sra, shdir, sub, jalr}
  function automatic logic [31:0] alu_fn(input logic [31:0] rs1, rs2, pc, imm,
                                         input logic [8:0] c);
    logic [31:0] a, b;
    logic signed [31:0] sa;
    a  = c[5] ? pc : rs1;
    b  = c[4] ? imm : rs2;
    sa = a;
    case (c[8:6])
      3'd0:    return c[1] ? a - b : a + b;
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return c[2] ? (c[3] ? 32'(sa >>> b[4:0]) : a >> b[4:0]) : a << b[4:0];
      default: return {31'b0, sa < $signed(b)};
    endcase
  endfunction

  function automatic logic [31:0] bta_fn(input logic [31:0] rs1, pc, imm, input logic [8:0] c);
    return c[0] ? rs1 + imm : pc + imm;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_arbiter #(.RR_EN(gi == 0), .CW(9)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(q_valid[0]), .req0_ready(rdy0[gi]),
      .req0_rs1(q_rs1[0]), .req0_rs2(q_rs2[0]), .req0_pc(q_pc[0]), .req0_imm(q_imm[0]),
      .req0_ctrl(q_ctrl[0]),
      .req1_valid(q_valid[1]), .req1_ready(rdy1[gi]),
      .req1_rs1(q_rs1[1]), .req1_rs2(q_rs2[1]), .req1_pc(q_pc[1]), .req1_imm(q_imm[1]),
      .req1_ctrl(q_ctrl[1]),
      .alu_rs1(a_rs1[gi]), .alu_rs2(a_rs2[gi]), .alu_pc(a_pc[gi]), .alu_imm(a_imm[gi]),
      .alu_ctrl(a_ctrl[gi]), .alu_z(a_z[gi]), .alu_bta(a_bta[gi]),
      .resp0_valid(rv0[gi]), .resp0_ready(p_ready[0]),
      .resp1_valid(rv1[gi]), .resp1_ready(p_ready[1]),
      .resp_z(rz[gi]), .resp_bta(rbta[gi]), .busy(bsy[gi])
    );
    assign a_z[gi]   = alu_fn(a_rs1[gi], a_rs2[gi], a_pc[gi], a_imm[gi], a_ctrl[gi]);
    assign a_bta[gi] = bta_fn(a_rs1[gi], a_pc[gi], a_imm[gi], a_ctrl[gi]);
  end

  // Transaction-level model: one pending op per instance, aged in clock edges since accept.
  bit          m_pend [2];
  int          m_age  [2];
  int          m_owner[2];
  bit          m_last [2];
  logic [31:0] m_rs1[2], m_rs2[2], m_pc[2], m_imm[2], m_z[2], m_bta[2];
  logic [8:0]  m_ctrl[2];
  int          acc_q0[$];
  int          acc_q1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int grant(input bit rr, input bit a, input bit b, input bit last);
    if (a && b) return rr ? (last ? 0 : 1) : 0;
    if (a) return 0;
    if (b) return 1;
    return -1;
  endfunction

  function automatic int model_grant(input int i);
    if (!rst_n || m_pend[i]) return -1;
    return grant(i == 0, q_valid[0], q_valid[1], m_last[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_age[i] = 0; m_owner[i] = 0; m_last[i] = 1;
      m_rs1[i] = '0; m_rs2[i] = '0; m_pc[i] = '0; m_imm[i] = '0; m_ctrl[i] = '0;
      m_z[i] = '0; m_bta[i] = '0;
    end
  endtask

  task automatic tick();
    int g;
    bit resp;
    if (!rst_n) model_reset();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      g    = model_grant(i);
      resp = m_pend[i] && m_age[i] >= 1;
      check($sformatf("i%0d req0_ready", i), 32'(rdy0[i]), 32'(g == 0));
      check($sformatf("i%0d req1_ready", i), 32'(rdy1[i]), 32'(g == 1));
      check($sformatf("i%0d resp0_valid", i), 32'(rv0[i]), 32'(resp && m_owner[i] == 0));
      check($sformatf("i%0d resp1_valid", i), 32'(rv1[i]), 32'(resp && m_owner[i] == 1));
      check($sformatf("i%0d busy", i), 32'(bsy[i]), 32'(m_pend[i]));
      check($sformatf("i%0d alu_rs1", i), a_rs1[i], m_rs1[i]);
      check($sformatf("i%0d alu_rs2", i), a_rs2[i], m_rs2[i]);
      check($sformatf("i%0d alu_pc", i), a_pc[i], m_pc[i]);
      check($sformatf("i%0d alu_imm", i), a_imm[i], m_imm[i]);
      check($sformatf("i%0d alu_ctrl", i), 32'(a_ctrl[i]), 32'(m_ctrl[i]));
      if (resp) begin
        check($sformatf("i%0d resp_z", i), rz[i], m_z[i]);
        check($sformatf("i%0d resp_bta", i), rbta[i], m_bta[i]);
      end
    end
    @(posedge clk);
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        g = model_grant(i);
        if (m_pend[i]) begin
          if (m_age[i] >= 1 && p_ready[m_owner[i]]) m_pend[i] = 0;
          else m_age[i]++;
        end else if (g >= 0) begin
          m_pend[i] = 1; m_age[i] = 0; m_owner[i] = g; m_last[i] = (g == 1);
          m_rs1[i] = q_rs1[g]; m_rs2[i] = q_rs2[g]; m_pc[i] = q_pc[g];
          m_imm[i] = q_imm[g]; m_ctrl[i] = q_ctrl[g];
          m_z[i]   = alu_fn(q_rs1[g], q_rs2[g], q_pc[g], q_imm[g], q_ctrl[g]);
          m_bta[i] = bta_fn(q_rs1[g], q_pc[g], q_imm[g], q_ctrl[g]);
          if (i == 0) acc_q0.push_back(g);
          else        acc_q1.push_back(g);
        end
      end
    end
    #1;
  endtask

  task automatic randomize_ops();
    for (int n = 0; n < 2; n++) begin
      q_rs1[n] = $urandom; q_rs2[n] = $urandom; q_pc[n] = $urandom;
      q_imm[n] = $urandom; q_ctrl[n] = 9'($urandom);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; q_valid = 2'b00;
    tick();
    rst_n = 1'b1;
    acc_q0.delete();
    acc_q1.delete();
  endtask

  int          exp_rr[4] = '{0, 1, 0, 1};
  logic [31:0] hold_z, hold_bta;

  initial begin
    rst_n = 1'b0; q_valid = 2'b00; p_ready = 2'b00;
    for (int n = 0; n < 2; n++) begin
      q_rs1[n] = '0; q_rs2[n] = '0; q_pc[n] = '0; q_imm[n] = '0; q_ctrl[n] = '0;
    end
    model_reset();
    tick();
    tick();
    rst_n = 1'b1;

    // single add on requester 0
    q_valid = 2'b01; q_rs1[0] = 32'd5; q_rs2[0] = 32'd3; q_ctrl[0] = 9'd0; p_ready = 2'b11;
    tick();
    q_valid = 2'b00;
    tick();
    check("add resp0_valid", 32'(rv0[0]), 32'd1);
    check("add resp_z", rz[0], 32'd8);
    tick();
    check("add busy after", 32'(bsy[0]), 32'd0);

    // continuous tie: round-robin alternates, fixed priority sticks to 0
    do_reset();
    q_valid = 2'b11; p_ready = 2'b11;
    repeat (12) begin
      randomize_ops();
      tick();
    end
    check("rr accepts", 32'(acc_q0.size()), 32'd4);
    check("fp accepts", 32'(acc_q1.size()), 32'd4);
    for (int k = 0; k < 4 && k < acc_q0.size() && k < acc_q1.size(); k++) begin
      check($sformatf("rr grant %0d", k), 32'(acc_q0[k]), 32'(exp_rr[k]));
      check($sformatf("fp grant %0d", k), 32'(acc_q1[k]), 32'd0);
    end

    // backpressure on requester 1 with a branch-target op
    do_reset();
    q_valid = 2'b10; p_ready = 2'b01;
    q_pc[1] = 32'h100; q_imm[1] = 32'h20; q_rs1[1] = 32'h7; q_rs2[1] = 32'h9; q_ctrl[1] = 9'd0;
    tick();
    q_valid = 2'b01;
    tick();
    check("bta resp_bta", rbta[0], 32'h120);
    hold_z = rz[0]; hold_bta = rbta[0];
    repeat (5) begin
      randomize_ops();
      tick();
      check("bp resp1_valid", 32'(rv1[0]), 32'd1);
      check("bp resp_z hold", rz[0], hold_z);
      check("bp resp_bta hold", rbta[0], hold_bta);
    end
    p_ready = 2'b10;
    tick();
    tick();

    // reset during EXEC discards the op; requester 1 is accepted right after release
    do_reset();
    q_valid = 2'b10; p_ready = 2'b11;
    randomize_ops();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst busy", 32'(bsy[0]), 32'd0);
    check("rst alu_rs1", a_rs1[0], 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 1500; c++) begin
      randomize_ops();
      q_valid = 2'($urandom);
      p_ready[0] = ($urandom_range(0, 9) < 7);
      p_ready[1] = ($urandom_range(0, 9) < 7);
      rst_n = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
